axi4_lite_reg_master: RTL
=========================

# axi4_lite_reg_master

Single-outstanding AXI4-Lite master translating a simple valid/ready command/response port into AXI4-Lite read and write transactions. Counterpart of the register-file slave: drives that slave (or any AXI4-Lite slave) from local control logic such as bring-up sequencers, configuration loaders or test harnesses. One transaction is in flight at a time; the response (read data plus resp code) is returned on a held response port.

## Interface
- ADDR_WIDTH, 32, AXI address width and cmd_addr width.
- AXI_DATA_WIDTH, 32, AXI data width; 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog limit, used only with the macro under Configuration; min 2.
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- if_axi  ifc_axi4_lite.master  -  AXI4-Lite bus.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  AXI_DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  input  AXI_DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  output  2  bresp or rresp, passed through unchanged.
- o_timeout  output  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- States: ST_IDLE, ST_WR (awvalid and/or wvalid asserted), ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_RSP.
- cmd_ready = (state == ST_IDLE) & rst_n. Accepted command fields are registered into addr/data/strb/write holding registers.
- ST_IDLE -> ST_WR on a write accept; awvalid and wvalid both rise next cycle. aw_done and w_done flags are tracked independently. Each valid drops in the cycle after its own handshake. ST_WR -> ST_WR_RESP once both flags are set, including when both handshakes land in the same cycle.
- ST_WR_RESP: bready = 1. On the bvalid handshake, capture bresp, set rsp_rdata = 0, go to ST_RSP.
- ST_IDLE -> ST_RD_ADDR on a read accept; arvalid = 1. Handshake -> ST_RD_DATA with rready = 1. Handshake captures rdata/rresp -> ST_RSP.
- ST_RSP: rsp_valid = 1, and rsp_rdata/rsp_resp are held stable until rsp_ready. Then -> ST_IDLE.
- AXI rules: valids never depend on the ready they wait for. Once asserted, a valid stays high with stable payload until its handshake. awprot = arprot = 3'b000. bready/rready are asserted only in their wait states.
- SLVERR/DECERR responses are not retried; they are reported via rsp_resp.
- Reset values: state ST_IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0; rsp_rdata = 0; rsp_resp = 2'b00; o_timeout = 0; holding registers = 0.
- Reset mid-transaction aborts immediately, and all valids/readies drop asynchronously. Slave and master share rst_n at system level; no partial-transaction recovery.

## Timing
- Command accepted at cycle 0. AXI valids are registered and assert at cycle 1.
- Write with slave always ready: aw/w handshakes at cycle 1, bready at cycle 2, earliest bvalid handshake at cycle 2, rsp_valid at cycle 3.
- Read with slave always ready: ar handshake at cycle 1, rready at cycle 2, earliest r handshake at cycle 2, rsp_valid at cycle 3.
- Against the register-file slave, reads add its one fetch cycle: rsp_valid at cycle 4.
- Back-to-back throughput: a new command can be accepted in the cycle after the rsp handshake. The minimum command period is 4 cycles.
- Slave stalls of any length just extend the wait state; no cycle limit on handshakes.

## Configuration
- AXI4_LITE_REG_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering ST_WR or ST_RD_ADDR and increments every cycle while state is not ST_IDLE or ST_RSP.
  - When the counter reaches TIMEOUT_CYCLES, o_timeout is set and stays set until reset. The counter saturates.
  - The FSM keeps waiting, because AXI forbids withdrawing a valid.
- Macro undefined: no counter is built, o_timeout = 0, and TIMEOUT_CYCLES is unused.

## Structure
- axi_lib_pkg gains the st_axi_lite_master_t enum (states above). It reuses the existing AXI4_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- Sub-module axi4_lite_master_watchdog: saturating counter with clear/enable/limit and a sticky flag. It is instantiated only under the macro.

## Test plan
- Write to 0x0000_0008, data 0xDEAD_BEEF, strb 0xF, slave always ready -> aw/w handshake at cycle 1, rsp_valid at cycle 3, rsp_resp = 2'b00, rsp_rdata = 0.
- Read from 0x0000_0004, slave returns 0x1234_5678 after a 5-cycle arready stall -> arvalid held high with stable araddr for 6 cycles, rsp_rdata = 0x1234_5678.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after cycle 1, awvalid held to cycle 4, exactly one B handshake, rsp_valid once.
- Read returns rresp = SLVERR with rsp_ready held low 4 cycles -> rsp_valid and rsp_resp = 2'b10 stable for 5 cycles, then cmd_ready reasserts.
- rst_n pulsed low while awvalid is high -> awvalid/wvalid/rsp_valid = 0 asynchronously; after release cmd_ready = 1 and no stale response appears.
- With the macro, TIMEOUT_CYCLES = 16, slave never asserts arready -> o_timeout rises 16 cycles after arvalid and stays high, arvalid still high. Without the macro, o_timeout remains 0.

Source files
------------

// File: rtl/axi_lib_pkg.sv
// Shared AXI definitions: response codes and the AXI4-Lite master state encoding.
package axi_lib_pkg;

   localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } st_axi_lite_master_t;

endpackage

// File: rtl/ifc_axi4_lite.sv
// AXI4-Lite bus bundle with master and slave views.
interface ifc_axi4_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_master_watchdog.sv
// Saturating cycle counter with a sticky flag raised when the count reaches LIMIT.
module axi4_lite_master_watchdog #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic flag
);
   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (enable && (count != LIMIT_C))
         count_next = count + 1'b1;
   end

   // The flag follows the next count so it rises in the same cycle the limit is hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         flag  <= 1'b0;
      end else begin
         count <= count_next;
         flag  <= flag | (count_next == LIMIT_C);
      end
   end
endmodule

// File: rtl/axi4_lite_reg_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command/response port.
// Optional watchdog enabled by defining AXI4_LITE_REG_MASTER_TIMEOUT_EN.
module axi4_lite_reg_master
   import axi_lib_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ifc_axi4_lite.master                if_axi,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        o_timeout
);
   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   st_axi_lite_master_t         state;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]       wstrb_q;
   logic                        aw_done;
   logic                        w_done;
   logic                        awvalid_q;
   logic                        wvalid_q;
   logic                        arvalid_q;
   logic                        bready_q;
   logic                        rready_q;
   logic                        rsp_valid_q;
   logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]                  rsp_resp_q;
   logic                        aw_fin;
   logic                        w_fin;

   assign cmd_ready = (state == ST_IDLE) & rst_n;

   // A channel counts as finished if it already handshook or is handshaking now.
   assign aw_fin = aw_done | (awvalid_q & if_axi.awready);
   assign w_fin  = w_done  | (wvalid_q  & if_axi.wready);

   // Main transaction FSM; every AXI valid/ready and response output is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= AXI4_RESP_OKAY;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     state     <= ST_WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                  end else begin
                     state     <= ST_RD_ADDR;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (awvalid_q && if_axi.awready) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (wvalid_q && if_axi.wready) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  state    <= ST_WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (if_axi.bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= if_axi.bresp;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RSP;
               end
            end
            ST_RD_ADDR: begin
               if (if_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (if_axi.rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= if_axi.rdata;
                  rsp_resp_q  <= if_axi.rresp;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign if_axi.awaddr  = addr_q;
   assign if_axi.awprot  = 3'b000;
   assign if_axi.awvalid = awvalid_q;
   assign if_axi.wdata   = wdata_q;
   assign if_axi.wstrb   = wstrb_q;
   assign if_axi.wvalid  = wvalid_q;
   assign if_axi.bready  = bready_q;
   assign if_axi.araddr  = addr_q;
   assign if_axi.arprot  = 3'b000;
   assign if_axi.arvalid = arvalid_q;
   assign if_axi.rready  = rready_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

`ifdef AXI4_LITE_REG_MASTER_TIMEOUT_EN
   logic wd_clear;
   logic wd_enable;

   assign wd_clear  = (state == ST_IDLE) & cmd_valid;
   assign wd_enable = (state != ST_IDLE) & (state != ST_RSP);

   axi4_lite_master_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (wd_clear),
      .enable (wd_enable),
      .flag   (o_timeout)
   );
`else
   assign o_timeout = 1'b0;
`endif
endmodule
